// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads, buffers returned words
// with their PC for the decoder, and on redirect flushes the buffer and discards in-flight reads.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, drop;
  logic [31:0]   pcq [MAX_OUTSTANDING];
  logic [QW-1:0] pcq_wr, pcq_rd;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [FW-1:0] fifo_wr, fifo_rd;
  logic [NW-1:0] fifo_count;

  logic          req_fire, pop, push;
  logic [CW-1:0] inflight, drop_after_redirect, outstanding_nxt;
  logic [NW-1:0] fifo_count_nxt;
  logic [31:0]   redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'd3;
  assign imem_req_addr    = pc;
  assign instr_valid      = (fifo_count != '0);
  assign instr            = fifo_data[fifo_rd];
  assign instr_pc         = fifo_pc[fifo_rd];

  // Credit: a request only issues when a buffer slot is reserved for its response;
  // dropped requests hold outstanding slots but never a buffer slot.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid
                     && (int'(outstanding) + int'(drop) < MAX_OUTSTANDING)
                     && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);
    req_fire = imem_req_valid && imem_req_ready;
    pop      = instr_valid && instr_ready;
    push     = imem_resp_valid && !redirect_valid && (drop == '0) && (outstanding != '0);
    inflight = outstanding + drop;
    drop_after_redirect = (imem_resp_valid && inflight != '0) ? inflight - CW'(1) : inflight;

    outstanding_nxt = outstanding;
    if (req_fire && !push)      outstanding_nxt = outstanding + CW'(1);
    else if (!req_fire && push) outstanding_nxt = outstanding - CW'(1);

    fifo_count_nxt = fifo_count;
    if (push && !pop)      fifo_count_nxt = fifo_count + NW'(1);
    else if (!push && pop) fifo_count_nxt = fifo_count - NW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight becomes a response to discard.
      pc          <= redirect_aligned;
      outstanding <= '0;
      drop        <= drop_after_redirect;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
    end else begin
      if (req_fire) begin
        pc     <= pc + 32'd4;
        pcq_wr <= pcq_inc(pcq_wr);
      end
      if (imem_resp_valid && drop != '0) drop <= drop - CW'(1);
      if (push) begin
        fifo_data[fifo_wr] <= imem_resp_data;
        fifo_pc[fifo_wr]   <= pcq[pcq_rd];
        fifo_wr            <= fifo_inc(fifo_wr);
        pcq_rd             <= pcq_inc(pcq_rd);
      end
      if (pop) fifo_rd <= fifo_inc(fifo_rd);
      outstanding <= outstanding_nxt;
      fifo_count  <= fifo_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with queued responses, scoreboard of expected
// {pc, word} pairs pushed on live responses and compared against the decoder side.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  logic        v5, rq5_ready, rs5_valid, ir5_ready, iv5, redirect5;
  logic [31:0] a5, rs5_data, i5, ip5, redirect5_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut5 (
    .clk(clk), .rst(rst),
    .imem_req_valid(v5), .imem_req_ready(rq5_ready),
    .imem_req_addr(a5),
    .imem_resp_valid(rs5_valid), .imem_resp_data(rs5_data),
    .redirect_valid(redirect5), .redirect_pc(redirect5_pc),
    .instr_valid(iv5), .instr_ready(ir5_ready),
    .instr(i5), .instr_pc(ip5)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } instr_t;
  typedef struct packed { logic [31:0] addr; logic live; } req_t;

  instr_t      exp_q[$];
  req_t        mem_q[$];
  logic [31:0] exp_pc;
  logic        resp_en;
  logic        first_seen;
  logic [31:0] first_pc;
  int          n_chk, n_fail;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, check outputs, advance the model.
  task automatic tick();
    instr_t e;
    req_t   r;
    imem_resp_valid = !rst && resp_en && (mem_q.size() > 0);
    imem_resp_data  = (mem_q.size() > 0) ? memword(mem_q[0].addr) : 32'h0;
    #1;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      exp_pc = RST_PC;
    end else begin
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && exp_q.size() != 0) begin
        check("instr_pc", instr_pc, exp_q[0].pc);
        check("instr", instr, exp_q[0].data);
      end
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
      if (redirect_valid) check("req_during_redirect", 32'(imem_req_valid), 32'd0);
      if (instr_valid && instr_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!first_seen) begin
          first_seen = 1'b1;
          first_pc   = e.pc;
        end
      end
      if (imem_resp_valid) begin
        r = mem_q.pop_front();
        if (r.live && !redirect_valid)
          exp_q.push_back('{pc: r.addr, data: memword(r.addr)});
      end
      if (redirect_valid) begin
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        exp_q.delete();
      end
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, live: !redirect_valid});
      if (redirect_valid)                     exp_pc = {redirect_pc[31:2], 2'b00};
      else if (imem_req_valid && imem_req_ready) exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic rst_checks();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", imem_req_addr, RST_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    imem_req_ready = 1'b0; resp_en = 1'b0;
    tick();
    rst_checks();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0; resp_en = 1'b0;
    first_seen = 1'b1; first_pc = '0; exp_pc = RST_PC;
    rq5_ready = 1'b0; rs5_valid = 1'b0; rs5_data = '0; ir5_ready = 1'b0;
    redirect5 = 1'b0; redirect5_pc = '0;
    @(negedge clk);

    // Streaming with a ready memory and decoder
    reset_dut();
    imem_req_ready = 1'b1; instr_ready = 1'b1; resp_en = 1'b1;
    repeat (24) tick();

    // Decoder stall fills the buffer and throttles requests
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_buffered", 32'(exp_q.size()), 32'd2);
    instr_ready = 1'b1;
    repeat (12) tick();

    // Redirect with two requests in flight
    reset_dut();
    imem_req_ready = 1'b1; instr_ready = 1'b1; resp_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    repeat (4) tick();
    check("t3_outstanding", 32'(mem_q.size()), 32'd2);
    check("t3_blocked", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    check("t3_next_addr", imem_req_addr, 32'h100);
    first_seen = 1'b0; resp_en = 1'b1;
    for (int i = 0; i < 20 && !first_seen; i++) tick();
    check("t3_first_seen", 32'(first_seen), 32'd1);
    check("t3_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response and a pop
    reset_dut();
    imem_req_ready = 1'b1; instr_ready = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    resp_en = 1'b1;
    tick();
    resp_en = 1'b0;
    check("t4_buffered", 32'(instr_valid), 32'd1);
    check("t4_resp_pending", 32'(mem_q.size()), 32'd1);
    instr_ready = 1'b1; resp_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    first_seen = 1'b0;
    tick();
    check("t4_pop_seen", 32'(first_seen), 32'd1);
    check("t4_popped_pc", first_pc, 32'h0);
    check("t4_valid_r1", 32'(instr_valid), 32'd0);
    repeat (12) tick();

    // Random traffic with occasional redirects
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      instr_ready    = ($urandom_range(9) < 7);
      resp_en        = ($urandom_range(9) < 6);
      if ($urandom_range(19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
      end
      tick();
    end

    // Reset mid-stream with responses pending
    imem_req_ready = 1'b1; instr_ready = 1'b1; resp_en = 1'b0;
    repeat (3) tick();
    check("t6_pending", 32'(mem_q.size() != 0), 32'd1);
    rst = 1'b1;
    tick();
    rst_checks();
    rst = 1'b0; resp_en = 1'b1;
    #1;
    check("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    check("t6_restart_addr", imem_req_addr, RST_PC);
    repeat (20) tick();

    // Drain everything still in flight
    imem_req_ready = 1'b0; instr_ready = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mem_q.size() != 0); i++) tick();
    check("drain_done", 32'(exp_q.size() + mem_q.size()), 32'd0);

    // PC wrap from a reset PC near the top of the address space
    check("t5_valid0", 32'(v5), 32'd1);
    check("t5_addr0", a5, 32'hFFFF_FFF8);
    rq5_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t5_addr1", a5, 32'hFFFF_FFFC);
    @(posedge clk); @(negedge clk);
    check("t5_blocked", 32'(v5), 32'd0);
    rs5_valid = 1'b1; rs5_data = 32'hCAFE_0001;
    @(posedge clk); @(negedge clk);
    rs5_valid = 1'b0;
    check("t5_instr_valid", 32'(iv5), 32'd1);
    check("t5_instr_pc", ip5, 32'hFFFF_FFF8);
    check("t5_instr", i5, 32'hCAFE_0001);
    ir5_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ir5_ready = 1'b0;
    check("t5_valid2", 32'(v5), 32'd1);
    check("t5_addr2", a5, 32'h0000_0000);
    rq5_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
